// File: rtl/hack_ram_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: FSM encoding, frame layout
// and the RAM geometry defaults that the data RAM also uses.
package hack_ram_loader_pkg;

  localparam int DEFAULT_DEPTH  = 16384;
  localparam int DEFAULT_ADDR_W = 14;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_CHECK,
    S_DAT_HI,
    S_DAT_LO,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/hack_idle_timer.sv
// Loadable down-counter that flags a stalled byte source. expire is asserted
// on the TIMEOUT-th running cycle after the last load.
module hack_idle_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (run && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/hack_ram_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs byte pairs into
// 16-bit words and writes them to the data RAM with explicit setup/strobe/hold.
module hack_ram_loader
  import hack_ram_loader_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [BYTES_PER_WORD*8-1:0] ram_in,
  output logic                        ram_write,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [ADDR_W:0]             words_loaded
);

  localparam int LEN_W = LEN_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(DEPTH - BASE_ADDR);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] next_addr;
  logic              xfer;
  logic              start_ok;
  logic              expire;

  assign rx_ready = (state inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO});
  assign busy     = !(state inside {S_IDLE, S_DONE, S_ERROR});
  assign xfer     = rx_valid && rx_ready;
  assign start_ok = start && !busy;

  hack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (xfer || start_ok),
    .run    (rx_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ram_write    <= 1'b0;
      ram_address  <= '0;
      ram_in       <= '0;
      cpu_reset    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      next_addr    <= ADDR_W'(BASE_ADDR);
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            next_addr    <= ADDR_W'(BASE_ADDR);
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[LEN_W-1:8] <= rx_data;
            state          <= S_LEN_LO;
          end else if (expire) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            state    <= S_CHECK;
          end else if (expire) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        // Reject any frame that would run past the top of the RAM, so the
        // address counter can never wrap.
        S_CHECK: begin
          if (len == '0) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else if (len > MAX_N) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else begin
            state <= S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          if (xfer) begin
            hi_byte <= rx_data;
            state   <= S_DAT_LO;
          end else if (expire) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        S_DAT_LO: begin
          if (xfer) begin
            ram_in      <= {hi_byte, rx_data};
            ram_address <= next_addr;
            state       <= S_SETUP;
          end else if (expire) begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
        // Address and data were registered on entry to SETUP and stay put
        // until HOLD ends, bracketing the write rising edge by a cycle.
        S_SETUP: begin
          ram_write <= 1'b1;
          state     <= S_STROBE;
        end
        S_STROBE: begin
          ram_write <= 1'b0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          next_addr    <= next_addr + ADDR_W'(1);
          if ((LEN_W'(words_loaded) + LEN_W'(1)) == len) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= S_DAT_HI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ram_loader.sv
// Directed bench for hack_ram_loader: frame loads, length limits, source
// stalls, idle timeout and reset during a write strobe.
module tb_hack_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [13:0] ram_address;
  logic [15:0] ram_in;
  logic        ram_write;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] words_loaded;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame [0:15];
  int          flen;
  logic [13:0] wa [0:15];
  logic [15:0] wd [0:15];
  int          nw = 0;
  bit          mon_en = 1'b1;

  logic        pw, pr, pend;
  logic [13:0] pa;
  logic [15:0] pd;

  hack_ram_loader #(
    .DEPTH     (16384),
    .ADDR_W    (14),
    .BASE_ADDR (0),
    .TIMEOUT   (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .ram_address  (ram_address),
    .ram_in       (ram_in),
    .ram_write    (ram_write),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: logs each strobe and checks the surrounding cycles.
  initial begin
    pw = 1'b0; pr = 1'b0; pend = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (mon_en && pend) begin
        check("hold_write", ram_write, 0);
        check("hold_addr", ram_address, pa);
        check("hold_data", ram_in, pd);
        check("hold_ready", rx_ready, 0);
      end
      pend = 1'b0;
      if (mon_en && ram_write) begin
        check("setup_write", pw, 0);
        check("setup_addr", pa, ram_address);
        check("setup_data", pd, ram_in);
        check("setup_ready", pr, 0);
        check("strobe_ready", rx_ready, 0);
        if (nw < 16) begin
          wa[nw] = ram_address;
          wd[nw] = ram_in;
        end
        nw++;
        pend = 1'b1;
      end
      pw = ram_write; pa = ram_address; pd = ram_in; pr = rx_ready;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns just before the clock edge that accepts the last byte.
  task automatic send(input bit stall);
    int i = 0;
    int guard = 0;
    while (i < flen && guard < 400) begin
      @(negedge clk);
      rx_data  = frame[i];
      rx_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rx_valid && rx_ready) i++;
      guard++;
    end
    check("send_bytes", i, flen);
  endtask

  task automatic wait_end();
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", done | error, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_reset", cpu_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_write", ram_write, 0);
    check("rst_words", words_loaded, 0);
    check("rst_ready", rx_ready, 0);
    reset = 1'b0;

    // Three-word load, source always valid.
    pulse_start();
    check("t1_cpu_reset", cpu_reset, 1);
    check("t1_busy", busy, 1);
    check("t1_ready", rx_ready, 1);
    frame[0] = 8'h00; frame[1] = 8'h03; frame[2] = 8'h12; frame[3] = 8'h34;
    frame[4] = 8'hAB; frame[5] = 8'hCD; frame[6] = 8'hFF; frame[7] = 8'hFF;
    flen = 8; nw = 0;
    send(1'b0);
    wait_end();
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_words", words_loaded, 3);
    check("t1_cpu_reset_low", cpu_reset, 0);
    check("t1_busy_low", busy, 0);
    check("t1_nwrites", nw, 3);
    check("t1_a0", wa[0], 14'd0);  check("t1_d0", wd[0], 16'h1234);
    check("t1_a1", wa[1], 14'd1);  check("t1_d1", wd[1], 16'hABCD);
    check("t1_a2", wa[2], 14'd2);  check("t1_d2", wd[2], 16'hFFFF);

    // Zero-length frame.
    pulse_start();
    check("t2_done_cleared", done, 0);
    check("t2_words_cleared", words_loaded, 0);
    frame[0] = 8'h00; frame[1] = 8'h00; flen = 2; nw = 0;
    send(1'b0);
    wait_end();
    check("t2_done", done, 1);
    check("t2_words", words_loaded, 0);
    check("t2_nwrites", nw, 0);
    check("t2_cpu_reset", cpu_reset, 0);

    // Oversize frame, N = 16385.
    pulse_start();
    frame[0] = 8'h40; frame[1] = 8'h01; flen = 2; nw = 0;
    send(1'b0);
    @(negedge clk); rx_valid = 1'b0;
    check("t3_check_error", error, 0);
    check("t3_check_busy", busy, 1);
    @(negedge clk);
    check("t3_error", error, 1);
    check("t3_cpu_reset", cpu_reset, 1);
    check("t3_busy", busy, 0);
    check("t3_nwrites", nw, 0);

    // Largest legal frame, N = 16384, is accepted; abort by reset afterwards.
    pulse_start();
    check("t4_error_cleared", error, 0);
    frame[0] = 8'h40; frame[1] = 8'h00; flen = 2;
    send(1'b0);
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
    check("t4_error", error, 0);
    check("t4_ready", rx_ready, 1);
    check("t4_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_cpu_reset", cpu_reset, 0);

    // Two-word frame with a randomly stalling source.
    pulse_start();
    frame[0] = 8'h00; frame[1] = 8'h02; frame[2] = 8'h5A; frame[3] = 8'hA5;
    frame[4] = 8'h0F; frame[5] = 8'hF0; flen = 6; nw = 0;
    send(1'b1);
    wait_end();
    check("t5_done", done, 1);
    check("t5_words", words_loaded, 2);
    check("t5_nwrites", nw, 2);
    check("t5_a0", wa[0], 14'd0);  check("t5_d0", wd[0], 16'h5AA5);
    check("t5_a1", wa[1], 14'd1);  check("t5_d1", wd[1], 16'h0FF0);

    // Idle timeout mid-word; a start pulse while busy must be ignored.
    pulse_start();
    frame[0] = 8'h00; frame[1] = 8'h02; frame[2] = 8'h12; flen = 3; nw = 0;
    send(1'b0);
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (m == 5) start = 1'b1;
      if (m == 6) begin
        start = 1'b0;
        check("t6_start_ignored", busy, 1);
      end
    end
    check("t6_error_early", error, 0);
    @(negedge clk);
    check("t6_error", error, 1);
    check("t6_cpu_reset", cpu_reset, 1);
    check("t6_words", words_loaded, 0);
    check("t6_nwrites", nw, 0);

    // Reset while word 1 is being strobed, then a clean reload.
    pulse_start();
    frame[0] = 8'h00; frame[1] = 8'h03; frame[2] = 8'h11; frame[3] = 8'h11;
    frame[4] = 8'h22; frame[5] = 8'h22; flen = 6; nw = 0;
    send(1'b0);
    @(negedge clk); rx_valid = 1'b0; mon_en = 1'b0;
    @(negedge clk);
    check("t7_strobe_write", ram_write, 1);
    check("t7_strobe_addr", ram_address, 14'd1);
    check("t7_strobe_data", ram_in, 16'h2222);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t7_write", ram_write, 0);
    check("t7_busy", busy, 0);
    check("t7_cpu_reset", cpu_reset, 0);
    @(negedge clk); mon_en = 1'b1; nw = 0;
    pulse_start();
    frame[0] = 8'h00; frame[1] = 8'h01; frame[2] = 8'h77; frame[3] = 8'h88; flen = 4;
    send(1'b0);
    wait_end();
    check("t7_done", done, 1);
    check("t7_words", words_loaded, 1);
    check("t7_nwrites", nw, 1);
    check("t7_a0", wa[0], 14'd0);
    check("t7_d0", wd[0], 16'h7788);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hack_ram_loader.md
Name: hack_ram_loader

Overview:
Boot-time program loader that sits directly upstream of the 16K-word data RAM and drives its address, in and write pins. It takes a byte stream from the serial receiver over a valid/ready handshake and packs byte pairs into 16-bit words. It writes those words to consecutive RAM addresses and holds the CPU in reset until the image is complete. The RAM latches on the rising edge of write, so the loader sequences setup, strobe and hold explicitly.

Parameters:
DEPTH, 16384, RAM size in words; sets the address range.
ADDR_W, 14, RAM address width.
BASE_ADDR, 0, first RAM address written.
TIMEOUT, 1000000, maximum idle cycles between bytes once a load has started.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
ram_address  output  ADDR_W  drives RAM address
ram_in  output  16  drives RAM in
ram_write  output  1  drives RAM write; high for exactly one cycle per word
cpu_reset  output  1  holds the CPU in reset while a load is in progress
busy  output  1  high in every state except IDLE, DONE and ERROR
done  output  1  load completed; held until the next start or reset
error  output  1  load aborted; held until the next start or reset
words_loaded  output  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, except cpu_reset, which is 0 in IDLE. The CPU runs after reset unless start is pulsed.
- Byte transfer occurs only when rx_valid and rx_ready are both high. rx_ready is high only in LEN_HI, LEN_LO, DAT_HI and DAT_LO.
- Frame format: a 16-bit word count N, MSB byte first, followed by N words, each MSB byte first.
- FSM states: IDLE, LEN_HI, LEN_LO, CHECK, DAT_HI, DAT_LO, SETUP, STROBE, HOLD, DONE, ERROR.
- Transitions on start: IDLE, DONE or ERROR go to LEN_HI. This clears done, error and words_loaded, sets cpu_reset and loads the next address with BASE_ADDR.
- LEN_HI goes to LEN_LO on a transfer; the byte becomes len[15:8]. LEN_LO goes to CHECK; the byte becomes len[7:0].
- CHECK, 1 cycle:
  - N = 0 goes to DONE.
  - N > DEPTH - BASE_ADDR goes to ERROR.
  - Otherwise go to DAT_HI.
- DAT_HI stores the high byte. DAT_LO stores the low byte, then goes to SETUP.
- SETUP: ram_address and ram_in are driven with the next address and the assembled word; ram_write is 0.
- STROBE: ram_write is 1, and address and data are unchanged.
- HOLD: ram_write is 0 and address and data are unchanged. words_loaded increments and the next address increments.
  - If words_loaded now equals N, go to DONE; otherwise go to DAT_HI.
- Write timing: ram_address and ram_in are stable from SETUP through HOLD, covering at least one full cycle on each side of the write rising edge.
- Minimum rate is 5 cycles per word, plus the wait for rx_valid.
- ram_address never wraps, because CHECK rejects any N that would exceed the RAM range.
- Timeout: an idle counter runs in LEN_HI, LEN_LO, DAT_HI and DAT_LO.
  - It clears on every transfer and on entry to LEN_HI.
  - Reaching TIMEOUT goes to ERROR.
- DONE: done is 1, cpu_reset is 0 and busy is 0.
- ERROR: error is 1, and cpu_reset stays 1 so a partial image never executes. ram_write is 0.
- start during busy is ignored.
- reset at any point, including during STROBE, immediately forces IDLE and drops ram_write. The word in flight may or may not be written.
- Arithmetic: N is compared as an unsigned 16-bit value against DEPTH - BASE_ADDR, extended to 16 bits.

Decomposition:
- Shared package holds:
  - the FSM state encoding (4-bit enum);
  - the frame constants: LEN_BYTES = 2, BYTES_PER_WORD = 2;
  - the default DEPTH and ADDR_W, shared with the RAM.
- One natural sub-module, hack_idle_timer: a loadable down-counter with clear and expire outputs, used for the timeout.
- The FSM, byte packer and address counter stay in the top module.

Test Plan:
- Load 3 words: reset, start, then bytes 00 03 12 34 AB CD FF FF, with rx_valid always high.
  - Writes 0x1234 to address 0, 0xABCD to address 1 and 0xFFFF to address 2.
  - Each ram_write pulse is 1 cycle wide, with address and data stable for the cycle before and the cycle after.
  - words_loaded = 3, done = 1, cpu_reset falls.
- Zero-length frame: bytes 00 00 -> DONE with no ram_write pulse, words_loaded = 0.
- Oversize: bytes 40 01 (N = 16385) -> error = 1 on the cycle after CHECK, no writes, cpu_reset stays 1.
- Stalled source: toggle rx_valid randomly during a 2-word frame.
  - Results are identical to the no-stall case.
  - rx_ready is 0 during SETUP, STROBE and HOLD.
- Timeout with TIMEOUT = 20: send 00 02 12, then nothing -> error rises exactly 20 cycles after the last transfer, with no write issued.
- Reset during STROBE of word 1 -> next cycle ram_write = 0, busy = 0, cpu_reset = 0.
  - A new start then reloads from BASE_ADDR.
